// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the multdiv issue controller: operator encoding, issue FSM states
// and the width of one intermediate-value slot.
package ibex_multdiv_issue_pkg;

    localparam int unsigned IMD_W = 34;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_e;

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    // Architectural divide-by-zero results: quotient all ones, remainder is the dividend.
    function automatic logic [31:0] div0_result(input md_op_e op, input logic [31:0] op_a);
        return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : op_a;
    endfunction

endpackage

// File: rtl/ibex_multdiv_imd_regs.sv
// The two 34-bit intermediate-value slots the multdiv unit reads and writes.
// Slot0 sits in the upper half of the bus and follows write enable bit 0.
module ibex_multdiv_imd_regs
    import ibex_multdiv_issue_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [2*IMD_W-1:0] imd_d,
    input  logic [1:0]         imd_we,
    output logic [2*IMD_W-1:0] imd_q
);

    logic [IMD_W-1:0] slot0_r;
    logic [IMD_W-1:0] slot1_r;

    // Slot0 storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot0_r <= {IMD_W{1'b0}};
        end else if (imd_we[0]) begin
            slot0_r <= imd_d[2*IMD_W-1:IMD_W];
        end
    end

    // Slot1 storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot1_r <= {IMD_W{1'b0}};
        end else if (imd_we[1]) begin
            slot1_r <= imd_d[IMD_W-1:0];
        end
    end

    assign imd_q = {slot0_r, slot1_r};

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Requester-side issue controller for the multicycle multiply/divide unit.
// Build macro MULTDIV_ISSUE_DIV0_SHORTCUT_EN answers divide-by-zero locally without the unit.
module ibex_multdiv_issue
    import ibex_multdiv_issue_pkg::*;
#(
    parameter logic RspReg = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        req_data_ind_timing_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic        md_mult_sel_o,
    output logic        md_div_sel_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_data_ind_timing_o,
    output logic [67:0] md_imd_val_q_o,
    input  logic [67:0] md_imd_val_d_i,
    input  logic [1:0]  md_imd_val_we_i,
    output logic        md_ready_id_o,
    input  logic [31:0] md_result_i,
    input  logic        md_valid_i
);

    issue_state_e state_r;
    issue_state_e state_nx_s;
    md_op_e       op_r;
    logic [1:0]   signed_r;
    logic [31:0]  op_a_r;
    logic [31:0]  op_b_r;
    logic         dit_r;
    logic [31:0]  rsp_result_r;

    md_op_e       req_op_s;
    logic         accept_s;
    logic         div0_s;
    logic         div_cls_s;
    logic         md_ready_id_s;
    logic         rsp_capture_s;

    assign req_op_s  = md_op_e'(req_operator_i);
    assign accept_s  = (state_r == ST_IDLE) && req_valid_i;
    assign div_cls_s = is_div_op(op_r);

`ifdef MULTDIV_ISSUE_DIV0_SHORTCUT_EN
    // Data-independent timing must still run the unit so latency does not leak operand values.
    assign div0_s = is_div_op(req_op_s) && (req_op_b_i == 32'd0) && !req_data_ind_timing_i;
`else
    assign div0_s = 1'b0;
`endif

    assign rsp_capture_s = RspReg && (state_r == ST_BUSY) && md_valid_i && !flush_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a flush that coincides with the unit retiring returns straight to idle
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_nx_s = div0_s ? ST_RESP : ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_nx_s = (md_valid_i && md_ready_id_s) ? ST_IDLE : ST_DRAIN;
                end else if (md_valid_i) begin
                    if (RspReg) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = rsp_ready_i ? ST_IDLE : ST_BUSY;
                    end
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DRAIN: begin
                state_nx_s = md_valid_i ? ST_IDLE : ST_DRAIN;
            end
            ST_RESP: begin
                state_nx_s = (flush_i || rsp_ready_i) ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; the unit cannot abort, so enables stay up while draining
    always_comb begin
        req_ready_o   = 1'b0;
        md_mult_en_o  = 1'b0;
        md_div_en_o   = 1'b0;
        md_mult_sel_o = 1'b0;
        md_div_sel_o  = 1'b0;
        md_ready_id_s = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_result_o  = 32'd0;
        case (state_r)
            ST_IDLE: begin
                req_ready_o = 1'b1;
            end
            ST_BUSY: begin
                md_mult_en_o  = !div_cls_s;
                md_mult_sel_o = !div_cls_s;
                md_div_en_o   = div_cls_s;
                md_div_sel_o  = div_cls_s;
                if (RspReg) begin
                    md_ready_id_s = 1'b1;
                end else begin
                    md_ready_id_s = rsp_ready_i;
                    rsp_valid_o   = md_valid_i && !flush_i;
                    rsp_result_o  = md_result_i;
                end
            end
            ST_DRAIN: begin
                md_mult_en_o  = !div_cls_s;
                md_mult_sel_o = !div_cls_s;
                md_div_en_o   = div_cls_s;
                md_div_sel_o  = div_cls_s;
                md_ready_id_s = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_o  = !flush_i;
                rsp_result_o = rsp_result_r;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    assign md_ready_id_o = md_ready_id_s;

    // Request capture; held stable for the unit until the next acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_r     <= MD_OP_MULL;
            signed_r <= 2'b00;
            op_a_r   <= 32'd0;
            op_b_r   <= 32'd0;
            dit_r    <= 1'b0;
        end else if (accept_s) begin
            op_r     <= req_op_s;
            signed_r <= req_signed_mode_i;
            op_a_r   <= req_op_a_i;
            op_b_r   <= req_op_b_i;
            dit_r    <= req_data_ind_timing_i;
        end
    end

    // Local response register, used by the registered response path and the div0 shortcut
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_result_r <= 32'd0;
        end else if (accept_s && div0_s) begin
            rsp_result_r <= div0_result(req_op_s, req_op_a_i);
        end else if (rsp_capture_s) begin
            rsp_result_r <= md_result_i;
        end
    end

    assign md_operator_o        = op_r;
    assign md_signed_mode_o     = signed_r;
    assign md_op_a_o            = op_a_r;
    assign md_op_b_o            = op_b_r;
    assign md_data_ind_timing_o = dit_r;

    ibex_multdiv_imd_regs u_imd_regs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .imd_d  (md_imd_val_d_i),
        .imd_we (md_imd_val_we_i),
        .imd_q  (md_imd_val_q_o)
    );

endmodule

// File: doc/ibex_multdiv_issue.md
Name: ibex_multdiv_issue

Overview:
Requester-side controller for the slow multicycle multiply/divide unit.
- Accepts one MUL/MULH/DIV/REM request at a time over a valid/ready interface.
- Registers the operands and holds the unit's enable, select and operands stable until the unit signals valid.
- Returns the result over a valid/ready response port, driving the unit's ready-id hold input from that port.
- Owns the two 34-bit intermediate-value registers the unit reads and writes. Sits in the EX stage between the issue logic and the unit.

Parameters:
RspReg, 1'b0, 0 = response passes combinationally from the unit; 1 = result captured into a local register, adding 1 cycle.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_operator_i  in  2  0 MUL, 1 MULH, 2 DIV, 3 REM
req_signed_mode_i  in  2  [0] op_a signed, [1] op_b signed
req_op_a_i  in  32  operand A
req_op_b_i  in  32  operand B
req_data_ind_timing_i  in  1  force data-independent timing
flush_i  in  1  discard in-flight operation
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  consumer accepts result
rsp_result_o  out  32  result
md_mult_en_o / md_div_en_o  out  1 each  unit enables
md_mult_sel_o / md_div_sel_o  out  1 each  unit selects
md_operator_o  out  2  held operator
md_signed_mode_o  out  2  held signed mode
md_op_a_o / md_op_b_o  out  32 each  held operands
md_data_ind_timing_o  out  1  held timing flag
md_imd_val_q_o  out  68  intermediate registers to unit
md_imd_val_d_i  in  68  intermediate next values
md_imd_val_we_i  in  2  intermediate write enables
md_ready_id_o  out  1  unit may retire (0 = hold result)
md_result_i  in  32  unit result
md_valid_i  in  1  unit result valid

Behaviour:
Reset:
- State IDLE.
- All held operand, operator and flag registers 0.
- imd registers 0; response register 0.
- All outputs 0, except req_ready_o = 1.

Interface ownership:
- rst_ni is asynchronous, active-low; clk_i is the clock.
- This block owns the two imd registers.

imd registers (independent of state):
- Slot0 = md_imd_val_q_o[67:34]. It loads md_imd_val_d_i[67:34] when md_imd_val_we_i[0] is set.
- Slot1 = md_imd_val_q_o[33:0]. It loads md_imd_val_d_i[33:0] when md_imd_val_we_i[1] is set.

FSM states: IDLE, BUSY, DRAIN, RESP (RESP exists only when RspReg=1).

IDLE:
- req_ready_o = 1.
- On req_valid_i: latch operator, signed mode, operands and timing flag; go to BUSY.
- md_* enables and selects are 0 in IDLE.

BUSY:
- Drive sel and en = 1 for the class: MUL/MULH use mult; DIV/REM use div.
- All md_* operands come from the latched registers and are stable for the whole operation.
- RspReg=0:
  - rsp_valid_o = md_valid_i, rsp_result_o = md_result_i, md_ready_id_o = rsp_ready_i.
  - md_valid_i & rsp_ready_i -> IDLE.
  - While rsp_ready_i is 0, the unit holds its result; rsp_valid_o and rsp_result_o must stay stable.
- RspReg=1:
  - md_ready_id_o = 1.
  - On md_valid_i, capture md_result_i and go to RESP.
  - RESP: rsp_valid_o = 1 from the register; rsp_ready_i -> IDLE.

Flush:
- flush_i in BUSY -> DRAIN. The unit has no abort, so sel/en stay driven.
- DRAIN: md_ready_id_o = 1, rsp_valid_o = 0. On md_valid_i -> IDLE with no response.
- flush_i in RESP drops the registered result -> IDLE.
- flush_i in IDLE or DRAIN has no effect.
- flush_i on the same cycle as a BUSY completion handshake: flush wins, no response delivered, go to IDLE.

Throughput and latency:
- No request is accepted outside IDLE, so back-to-back operations incur a 1-cycle bubble.
- Latency from acceptance to first rsp_valid_o = 1 + unit latency (+1 when RspReg=1).

Reset mid-operation: all state returns to reset values immediately; no response is produced.

Optional Feature:
MULTDIV_ISSUE_DIV0_SHORTCUT_EN:
- When defined: a DIV/REM request with req_op_b_i==0 and req_data_ind_timing_i==0 never enables the unit.
- IDLE goes directly to a 1-cycle-later response state.
- Result: DIV -> 32'hFFFFFFFF; REM -> req_op_a_i.
- Flush applies as in RESP.
- When undefined: all requests go to the unit.

Decomposition:
- Shared package: operator encoding enum (MD_OP_MULL/MULH/DIV/REM = 0..3) and the issue FSM state enum, including the imd slot width constant (34).
- Sub-module ibex_multdiv_imd_regs: the two write-enabled 34-bit registers with async reset.

Test Plan:
1. MUL 7*6, rsp_ready_i=1 -> rsp_result_o=42, one response, req_ready_o high the cycle after.
2. MULH signed/signed 0x80000000*0x80000000 -> 0x40000000; MULH unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV signed -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. Hold rsp_ready_i=0 for 5 cycles -> result stable, md_ready_id_o=0, no imd slot0 writes.
4. flush_i 3 cycles into DIV 100/7 -> no rsp_valid_o, req_ready_o asserted only after md_valid_i; next MUL 3*3 returns 9.
5. DIV 5/0 (timing=0) -> 0xFFFFFFFF. With the macro, md_div_en_o never asserts and the response comes 1 cycle after acceptance.
6. rst_ni low mid-MULH -> outputs at reset values; a new MUL 2*2 after reset -> 4. Repeat scenarios 1-5 with RspReg=1.
